rc4_stream_xor: RTL

Downstream stage of the RC4 keystream generator. Requests one keystream block, captures the `NUMS_OF_BYTES` cipher-key bytes when the generator signals `done`, and XORs them byte-by-byte onto a valid/ready plaintext stream. The result is a valid/ready ciphertext stream. Encryption and decryption are the same operation.

---
 rtl/rc4_pkg.sv | 18 +
 rtl/rc4_ks_buffer.sv | 37 +++
 rtl/rc4_stream_xor.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// rc4_pkg -- definitions shared by the RC4 keystream consumer stages.
//   state_t            : control states of rc4_stream_xor (2-bit encoding)
//   byte_t             : one data / keystream byte
//   NUMS_OF_BYTES_DEF  : default keystream bytes per generator block
package rc4_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      STREAM = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   typedef logic [7:0] byte_t;

   localparam int unsigned NUMS_OF_BYTES_DEF = 4;

endpackage

// File: rtl/rc4_ks_buffer.sv
// rc4_ks_buffer -- holds one keystream block and returns the byte selected by idx.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load      : capture strobe for ks_data
//   ks_data   : keystream block, byte n at [n*8 +: 8]
//   idx       : byte select
//   ks_byte   : selected keystream byte (combinational)
module rc4_ks_buffer
   import rc4_pkg::*;
#(
   parameter int unsigned NUMS_OF_BYTES = NUMS_OF_BYTES_DEF,
   parameter int unsigned IDX_W         = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load,
   input  logic [NUMS_OF_BYTES*8-1:0] ks_data,
   input  logic [IDX_W-1:0]           idx,
   output byte_t                      ks_byte
);

   logic [NUMS_OF_BYTES*8-1:0] key_buf;

   // NOTE: this storage is a handful of flops, not a RAM, so it takes the
   // async reset like every other register and a fresh block reads as zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_buf <= '0;
      end else if (load) begin
         key_buf <= ks_data;
      end
   end

   // idx never exceeds NUMS_OF_BYTES-1 because the parent ends the message there.
   assign ks_byte = key_buf[idx*8 +: 8];

endmodule

// File: rtl/rc4_stream_xor.sv
// rc4_stream_xor -- requests one RC4 keystream block and XORs it byte by byte
// onto a valid/ready plaintext stream, producing a valid/ready ciphertext stream.
// Optional feature macro: RC4_STREAM_XOR_BYPASS_EN (adds 'bypass', sampled with go;
// when set the message skips the keystream request and passes data unchanged).
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   go                            : one-cycle message start, sampled in IDLE
//   ks_req / ks_done / ks_data    : keystream generator request / done / block
//   in_valid/in_ready/in_data/in_last     : plaintext stream
//   out_valid/out_ready/out_data/out_last : ciphertext stream
//   busy                          : not IDLE
//   err                           : sticky overrun, cleared by the next go
module rc4_stream_xor
   import rc4_pkg::*;
#(
   parameter int unsigned NUMS_OF_BYTES = NUMS_OF_BYTES_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
`ifdef RC4_STREAM_XOR_BYPASS_EN
   input  logic                       bypass,
`endif
   input  logic                       go,
   output logic                       ks_req,
   input  logic                       ks_done,
   input  logic [NUMS_OF_BYTES*8-1:0] ks_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  byte_t                      in_data,
   input  logic                       in_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output byte_t                      out_data,
   output logic                       out_last,
   output logic                       busy,
   output logic                       err
);

   localparam int unsigned IDX_W = (NUMS_OF_BYTES > 1) ? $clog2(NUMS_OF_BYTES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUMS_OF_BYTES - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q;
   logic             ks_load;
   logic             accept;
   logic             at_limit;
   logic             msg_end;
   logic             use_bypass;
   state_t           go_target;
   byte_t            ks_byte;
   byte_t            tx_byte;

`ifdef RC4_STREAM_XOR_BYPASS_EN
   logic bypass_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bypass_q <= 1'b0;
      end else if (state_q == IDLE && go) begin
         bypass_q <= bypass;
      end
   end

   assign use_bypass = bypass_q;
   assign go_target  = bypass ? STREAM : REQ;
`else
   assign use_bypass = 1'b0;
   assign go_target  = REQ;
`endif

   rc4_ks_buffer #(
      .NUMS_OF_BYTES (NUMS_OF_BYTES),
      .IDX_W         (IDX_W)
   ) u_ks_buffer (
      .clk     (clk),
      .rst     (rst),
      .load    (ks_load),
      .ks_data (ks_data),
      .idx     (idx_q),
      .ks_byte (ks_byte)
   );

   // The output register may refill in the same cycle it drains.
   assign in_ready = (state_q == STREAM) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign at_limit = (idx_q == IDX_LAST);
   assign msg_end  = in_last || at_limit;
   assign tx_byte  = use_bypass ? in_data : (in_data ^ ks_byte);
   assign busy     = (state_q != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every output of this block is given a default before the case, so
   // no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      ks_req  = 1'b0;
      ks_load = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (go) state_d = go_target;
         end
         REQ: begin
            ks_req = 1'b1;
            if (ks_done) begin
               ks_load = 1'b1;
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (accept && msg_end) state_d = DRAIN;
         end
         DRAIN: begin
            if (out_valid && out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: registered state is updated only with non-blocking assignments so
   // every flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         err       <= 1'b0;
      end else begin
         if (state_q == IDLE && go) begin
            err   <= 1'b0;
            idx_q <= '0;   // bypass messages start streaming without a capture
         end
         if (ks_load) begin
            idx_q <= '0;
         end
         if (accept) begin
            out_data  <= tx_byte;
            out_valid <= 1'b1;
            out_last  <= msg_end;
            idx_q     <= idx_q + IDX_W'(1);
            // The block is exhausted but the message is not: flag it, never wrap.
            if (at_limit && !in_last) err <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
